dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 256x32 data memory between two requesters.
  - Port 0: core load/store stage.
  - Port 1: debug/DMA loader.
- Accepts one request per transaction, drives memory address/write controls, and returns read data as a registered response with valid/ready backpressure.
- Round-robin arbitration prevents either port from starving the other.

Parameters:
- ADDR_W, 8: memory word-address width; request address bits [ADDR_W-1:0] used, upper bits ignored.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_we  in  1  port 0 write (1) / read (0)
- req0_addr  in  32  port 0 address
- req0_wdata  in  DATA_W  port 0 write data
- resp0_valid  out  1  port 0 response available
- resp0_ready  in  1  port 0 consumes response
- resp0_rdata  out  DATA_W  port 0 read data (0 for writes)
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, resp1_valid, resp1_ready, resp1_rdata: as port 0, for port 1
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data for mem_addr

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; rr_ptr=0 (port 0 favoured first).
  - resp*_valid=0, resp*_rdata=0.
  - Reset mid-transaction discards any pending response.
  - A write already strobed before reset is not undone.
- FSM states: IDLE, RESP.
- IDLE:
  - grant = requester with valid; if both valid, the port selected by rr_ptr.
  - req*_ready is combinational: 1 only for the granted port in IDLE, 0 in RESP.
  - Accept = valid & ready.
  - mem_addr/mem_we/mem_wdata are driven combinationally from the granted request.
  - mem_we = granted we & accept. Otherwise mem_we=0, mem_addr=0, mem_wdata=0.
- On accept:
  - Capture mem_rdata (read) or 0 (write) into that port's resp_rdata.
  - Set its resp_valid=1; go to RESP.
  - rr_ptr = the other port.
  - Latency: response visible the cycle after accept.
- RESP:
  - Hold resp_valid/resp_rdata stable until resp_ready=1.
  - On handshake: clear resp_valid, return to IDLE.
  - No new request is accepted in the handshake cycle; max throughput is one transaction per 2 cycles.
- resp_ready is ignored when resp_valid=0.
- Only one resp_valid may be high at any time.
- Single valid requester is always granted regardless of rr_ptr; rr_ptr still toggles to the other port.
- Requesters must hold req fields stable while valid && !ready.
- Address wrap: req_addr bits above ADDR_W ignored, so 0x100 aliases 0x00.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With it, an extra input port req1_lock (1 bit) is present.
  - When port 1 is accepted with req1_lock=1, a lock flag is set.
  - While locked, arbitration grants only port 1; port 0 waits with ready=0.
  - Lock clears when port 1 is accepted with req1_lock=0, or on reset.
  - rr_ptr does not advance while locked.
- Without it, there is no req1_lock port and no lock flag; pure round-robin.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both valids high -> all ready/resp_valid=0, mem_we=0. After release, port 0 granted first.
- Write then read on port 0:
  - Write 0xDEADBEEF to addr 0x10 -> mem_we=1, mem_addr=0x10 in the accept cycle; resp0_valid next cycle with rdata=0.
  - Read addr 0x10 -> resp0_rdata=0xDEADBEEF.
- Contention: both ports valid continuously with reads -> grants alternate 0,1,0,1; each response follows its accept by one cycle.
- Backpressure: resp1_ready=0 for 5 cycles -> resp1_valid and rdata held stable; req0_ready stays 0 throughout; port 0 is granted only after the handshake, in the next IDLE cycle.
- Address alias: write 0x12345678 to addr 0x104 -> read of addr 0x04 returns 0x12345678.
- With DMEM_ARB_LOCK_EN: port 1 performs 3 locked writes while port 0 is valid -> port 0 is not granted until port 1's unlocked request is accepted, then port 0 is granted next.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response/memory bundle shared by dmem_arbiter and its environment.
// req1_lock exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [31:0]       req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              resp0_valid;
    logic              resp0_ready;
    logic [DATA_W-1:0] resp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [31:0]       req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp1_valid;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp1_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic              req1_lock;
`endif

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, resp0_ready,
        output req0_ready, resp0_valid, resp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, resp1_ready,
`ifdef DMEM_ARB_LOCK_EN
        input  req1_lock,
`endif
        output req1_ready, resp1_valid, resp1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory side.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, resp0_ready,
        input  req0_ready, resp0_valid, resp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, resp1_ready,
`ifdef DMEM_ARB_LOCK_EN
        output req1_lock,
`endif
        input  req1_ready, resp1_valid, resp1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for a single-port data memory, registered responses.
// Optional port-1 bus lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {StIdle, StResp} state_e;

    state_e            r_state;
    logic              r_rr_ptr;
    logic              r_resp0_valid;
    logic              r_resp1_valid;
    logic [DATA_W-1:0] r_resp0_rdata;
    logic [DATA_W-1:0] r_resp1_rdata;

    logic              w_idle;
    logic              w_locked;
    logic              w_gnt_valid;
    logic              w_gnt_port;
    logic              w_gnt_we;
    logic [31:0]       w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_rsp_hs;
    logic              w_unused_addr;

`ifdef DMEM_ARB_LOCK_EN
    logic r_lock;
    assign w_locked = r_lock;
`else
    assign w_locked = 1'b0;
`endif

    // Gating with rst_n keeps ready and the write strobe low while reset is held.
    assign w_idle = (r_state == StIdle) && rst_n;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_port  = 1'b0;
        if (w_idle) begin
            if (w_locked) begin
                w_gnt_valid = bus.req1_valid;
                w_gnt_port  = 1'b1;
            end else if (bus.req0_valid && bus.req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_port  = r_rr_ptr;
            end else if (bus.req0_valid) begin
                w_gnt_valid = 1'b1;
            end else if (bus.req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_port  = 1'b1;
            end
        end
    end

    assign w_gnt_we    = w_gnt_port ? bus.req1_we    : bus.req0_we;
    assign w_gnt_addr  = w_gnt_port ? bus.req1_addr  : bus.req0_addr;
    assign w_gnt_wdata = w_gnt_port ? bus.req1_wdata : bus.req0_wdata;
    assign w_cap_data  = w_gnt_we ? '0 : bus.mem_rdata;

    assign bus.req0_ready = w_gnt_valid && !w_gnt_port;
    assign bus.req1_ready = w_gnt_valid && w_gnt_port;

    assign bus.mem_we    = w_gnt_valid && w_gnt_we;
    assign bus.mem_addr  = w_gnt_valid ? w_gnt_addr[ADDR_W-1:0] : '0;
    assign bus.mem_wdata = w_gnt_valid ? w_gnt_wdata : '0;

    // Upper address bits alias onto the memory, so they are intentionally dropped.
    assign w_unused_addr = ^{bus.req0_addr[31:ADDR_W], bus.req1_addr[31:ADDR_W]};

    assign w_rsp_hs = (r_resp0_valid && bus.resp0_ready) || (r_resp1_valid && bus.resp1_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_rr_ptr      <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_rdata <= '0;
            r_resp1_rdata <= '0;
`ifdef DMEM_ARB_LOCK_EN
            r_lock        <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_gnt_valid) begin
                        if (w_gnt_port) begin
                            r_resp1_valid <= 1'b1;
                            r_resp1_rdata <= w_cap_data;
                        end else begin
                            r_resp0_valid <= 1'b1;
                            r_resp0_rdata <= w_cap_data;
                        end
                        if (!w_locked) r_rr_ptr <= ~w_gnt_port;
`ifdef DMEM_ARB_LOCK_EN
                        if (w_gnt_port) r_lock <= bus.req1_lock;
`endif
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    if (w_rsp_hs) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_state       <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.resp0_valid = r_resp0_valid;
    assign bus.resp1_valid = r_resp1_valid;
    assign bus.resp0_rdata = r_resp0_rdata;
    assign bus.resp1_rdata = r_resp1_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256x32 behavioural memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    logic [31:0] mem [256];

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory contents are seeded during reset: word i holds 0xA0000000 | i.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    initial begin
        logic        port;
        logic [31:0] exp_addr;

        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 32'h20; bus.req0_wdata = '0;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 32'h30; bus.req1_wdata = '0;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        bus.req1_lock = 1'b0;
`endif

        // Reset held two cycles with both requesters valid.
        tick();
        tick();
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst_rvalid0", 32'(bus.resp0_valid), 32'd0);
        chk("rst_rvalid1", 32'(bus.resp1_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rdata0", bus.resp0_rdata, 32'd0);

        // First grant after reset goes to port 0.
        rst_n = 1'b1;
        #1;
        chk("first_ready0", 32'(bus.req0_ready), 32'd1);
        chk("first_ready1", 32'(bus.req1_ready), 32'd0);
        chk("first_addr", 32'(bus.mem_addr), 32'h20);
        tick();
        chk("first_rvalid0", 32'(bus.resp0_valid), 32'd1);
        chk("first_rdata0", bus.resp0_rdata, 32'hA000_0020);
        chk("first_rvalid1", 32'(bus.resp1_valid), 32'd0);
        chk("first_resp_ready1", 32'(bus.req1_ready), 32'd0);
        tick();

        // Contention: grants alternate 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            port     = (i % 2 == 0);
            exp_addr = port ? 32'h30 : 32'h20;
            chk("cont_ready0", 32'(bus.req0_ready), 32'(!port));
            chk("cont_ready1", 32'(bus.req1_ready), 32'(port));
            chk("cont_addr", 32'(bus.mem_addr), exp_addr);
            tick();
            chk("cont_rvalid", 32'(port ? bus.resp1_valid : bus.resp0_valid), 32'd1);
            chk("cont_rvalid_other", 32'(port ? bus.resp0_valid : bus.resp1_valid), 32'd0);
            chk("cont_rdata", port ? bus.resp1_rdata : bus.resp0_rdata, 32'hA000_0000 | exp_addr);
            tick();
        end

        // Write then read on port 0.
        bus.req1_valid = 1'b0;
        bus.req0_we = 1'b1; bus.req0_addr = 32'h10; bus.req0_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_mem_we", 32'(bus.mem_we), 32'd1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_rvalid0", 32'(bus.resp0_valid), 32'd1);
        chk("wr_rdata0", bus.resp0_rdata, 32'd0);
        chk("wr_resp_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        bus.req0_we = 1'b0;
        #1;
        chk("rd_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("rd_rdata0", bus.resp0_rdata, 32'hDEAD_BEEF);
        tick();

        // Backpressure on port 1 while port 0 waits.
        bus.req0_addr = 32'h20;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 32'h30;
        bus.resp1_ready = 1'b0;
        #1;
        chk("bp_ready1", 32'(bus.req1_ready), 32'd1);
        chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(bus.resp1_valid), 32'd1);
            chk("bp_hold_rdata", bus.resp1_rdata, 32'hA000_0030);
            chk("bp_hold_ready0", 32'(bus.req0_ready), 32'd0);
            tick();
        end
        bus.resp1_ready = 1'b1;
        #1;
        chk("bp_hs_ready0", 32'(bus.req0_ready), 32'd0);
        chk("bp_hs_valid", 32'(bus.resp1_valid), 32'd1);
        tick();
        chk("bp_after_valid1", 32'(bus.resp1_valid), 32'd0);
        chk("bp_after_ready0", 32'(bus.req0_ready), 32'd1);
        chk("bp_after_addr", 32'(bus.mem_addr), 32'h20);
        tick();
        chk("bp_after_rvalid0", 32'(bus.resp0_valid), 32'd1);
        tick();

        // Address alias: 0x104 maps onto word 0x04.
        bus.req0_we = 1'b1; bus.req0_addr = 32'h104; bus.req0_wdata = 32'h1234_5678;
        #1;
        chk("alias_mem_addr", 32'(bus.mem_addr), 32'h04);
        tick();
        tick();
        bus.req0_we = 1'b0; bus.req0_addr = 32'h04;
        tick();
        chk("alias_rdata", bus.resp0_rdata, 32'h1234_5678);
        tick();

`ifdef DMEM_ARB_LOCK_EN
        // Three locked writes on port 1 starve port 0 until the unlocked one.
        bus.req0_addr = 32'h20;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req1_addr  = 32'h40 + i;
            bus.req1_wdata = 32'h5500 + i;
            #1;
            chk("lock_ready1", 32'(bus.req1_ready), 32'd1);
            chk("lock_ready0", 32'(bus.req0_ready), 32'd0);
            tick();
            tick();
        end
        bus.req1_lock = 1'b0; bus.req1_addr = 32'h43;
        #1;
        chk("unlock_ready1", 32'(bus.req1_ready), 32'd1);
        chk("unlock_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        tick();
        chk("post_lock_ready0", 32'(bus.req0_ready), 32'd1);
        chk("post_lock_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
